// File: rtl/apb2axi_pkg.sv
// Shared types and defaults for the APB-to-AXI request arbiter.
package apb2axi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NUM_REQ     = 2;
  localparam int unsigned DEF_ENTRY_WIDTH = 64;
  localparam int unsigned DEF_MAX_OUT     = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned src_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb2axi_rr_pick.sv
// Combinational round-robin picker: first candidate at or above ptr, with wrap.
module apb2axi_rr_pick
  import apb2axi_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = src_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [IDX_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] excl,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] cand;

  assign cand = elig & ~excl;

  // Scan NUM_REQ positions starting at ptr; first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned     j;
      logic [IDX_W-1:0] jn;
      j = 32'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jn = IDX_W'(j);
      if (!found && cand[jn]) begin
        found = 1'b1;
        idx   = jn;
      end
    end
  end

endmodule

// File: rtl/apb2axi_req_arb.sv
// Round-robin arbiter feeding the shared request FIFO, with per-requester
// outstanding credit limits. Optional per-requester grant statistics are
// enabled with the APB2AXI_ARB_STATS_EN macro.
module apb2axi_req_arb
  import apb2axi_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter  int unsigned ENTRY_WIDTH = DEF_ENTRY_WIDTH,
  parameter  int unsigned MAX_OUT     = DEF_MAX_OUT,
  localparam int unsigned SRC_W       = src_width(NUM_REQ),
  localparam int unsigned CNT_W       = $clog2(MAX_OUT + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ENTRY_WIDTH-1:0] req_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ENTRY_WIDTH-1:0]         out_data,
  output logic [SRC_W-1:0]               out_src,
  input  logic [NUM_REQ-1:0]             done,
  output logic                           busy
`ifdef APB2AXI_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]          grant_cnt
`endif
);

  arb_state_e         state;
  logic [SRC_W-1:0]   gnt_idx;
  logic [SRC_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt [NUM_REQ];

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] push_oh;
  logic [SRC_W-1:0]   nxt_ptr;
  logic [SRC_W-1:0]   pick_ptr;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_found;
  logic               hs;

  assign hs       = (state == GRANT) && out_ready && !reset;
  assign push_oh  = grant_oh & {NUM_REQ{hs}};
  assign nxt_ptr  = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
  // One picker serves both cases: IDLE searches from ptr with nothing
  // excluded; GRANT searches from the post-handshake ptr excluding the winner.
  assign pick_ptr = (state == GRANT) ? nxt_ptr : ptr;

  // Eligibility and the one-hot of the current grant.
  always_comb begin
    elig     = '0;
    grant_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      elig[i]     = req_valid[i] && (cnt[i] < CNT_W'(MAX_OUT));
      grant_oh[i] = (state == GRANT) && (gnt_idx == SRC_W'(i));
    end
  end

  apb2axi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (SRC_W)
  ) u_pick (
    .elig  (elig),
    .ptr   (pick_ptr),
    .excl  (grant_oh),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Push-side outputs derived from registered grant state.
  always_comb begin
    out_valid = (state == GRANT) && !reset;
    out_src   = gnt_idx;
    req_ready = grant_oh & {NUM_REQ{out_ready && !reset}};
    out_data  = '0;
    busy      = (state == GRANT);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) out_data = req_data[i*ENTRY_WIDTH +: ENTRY_WIDTH];
      if (cnt[i] != '0) busy = 1'b1;
    end
  end

  // Arbitration FSM: registered grant, same-cycle re-pick on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt_idx <= '0;
      ptr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state   <= GRANT;
            gnt_idx <= pick_idx;
          end
        end
        GRANT: begin
          if (out_ready) begin
            ptr <= nxt_ptr;
            if (pick_found) gnt_idx <= pick_idx;
            else            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outstanding credit counters; push and done together cancel out.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (reset) begin
        cnt[i] <= '0;
      end else if (push_oh[i] && !done[i]) begin
        cnt[i] <= cnt[i] + CNT_W'(1);
      end else if (!push_oh[i] && done[i] && (cnt[i] != '0)) begin
        cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

`ifdef APB2AXI_ARB_STATS_EN
  logic [31:0] gcnt [NUM_REQ];

  // Free-running per-requester handshake counters.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (reset)           gcnt[i] <= '0;
      else if (push_oh[i]) gcnt[i] <= gcnt[i] + 32'd1;
    end
  end

  // Flatten counters onto the stats port.
  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[i*32 +: 32] = gcnt[i];
  end
`endif

endmodule

// File: tb/tb_apb2axi_req_arb.sv
// Self-checking bench for apb2axi_req_arb: directed scenarios plus a
// randomized run checked against a behavioural model of the arbitration rules.
module tb_apb2axi_req_arb;

  localparam int N   = 3;
  localparam int W   = 16;
  localparam int MAX = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [1:0]      out_src;
  logic [N-1:0]    done;
  logic            busy;
`ifdef APB2AXI_ARB_STATS_EN
  logic [N*32-1:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  apb2axi_req_arb #(
    .NUM_REQ     (N),
    .ENTRY_WIDTH (W),
    .MAX_OUT     (MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .done      (done),
    .busy      (busy)
`ifdef APB2AXI_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural reference model ----------------
  bit         m_grant;
  int         m_gnt;
  int         m_ptr;
  int         m_cnt [N];
  bit [N-1:0] m_acc;
  int unsigned m_gc [N];

  function automatic bit [N-1:0] onehot(input int i);
    bit [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit [N-1:0] m_elig();
    bit [N-1:0] e;
    for (int i = 0; i < N; i++) e[i] = req_valid[i] && (m_cnt[i] < MAX);
    return e;
  endfunction

  // First set bit of mask at or after start, wrapping; -1 if none.
  function automatic int pick(input bit [N-1:0] mask, input int start);
    int r;
    r = -1;
    for (int k = 0; k < N; k++)
      if (r < 0 && mask[(start + k) % N]) r = (start + k) % N;
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_grant <= 1'b0;
      m_gnt   <= 0;
      m_ptr   <= 0;
      m_acc   <= '0;
      for (int i = 0; i < N; i++) begin
        m_cnt[i] <= 0;
        m_gc[i]  <= 0;
      end
    end else begin
      m_acc <= (m_grant && out_ready) ? onehot(m_gnt) : '0;
      for (int i = 0; i < N; i++) begin
        if (m_grant && out_ready && m_gnt == i) begin
          m_gc[i] <= m_gc[i] + 1;
          if (!done[i]) m_cnt[i] <= m_cnt[i] + 1;
        end else if (done[i] && m_cnt[i] > 0) begin
          m_cnt[i] <= m_cnt[i] - 1;
        end
      end
      if (!m_grant) begin
        if (pick(m_elig(), m_ptr) >= 0) begin
          m_grant <= 1'b1;
          m_gnt   <= pick(m_elig(), m_ptr);
        end
      end else if (out_ready) begin
        m_ptr <= (m_gnt + 1) % N;
        if (pick(m_elig() & ~onehot(m_gnt), (m_gnt + 1) % N) >= 0)
          m_gnt <= pick(m_elig() & ~onehot(m_gnt), (m_gnt + 1) % N);
        else
          m_grant <= 1'b0;
      end
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready got %0h exp 0", req_ready); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
    checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL reset_out_src got %0h exp 0", out_src); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
    reset = 1'b0;
    cyc();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got valid=%0h busy=%0h exp 0 0", out_valid, busy); end
  endtask

  task automatic test_single();
    set_data(0, 16'hA5C3);
    req_valid = 3'b001;
    out_ready = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0h exp 1", out_valid); end
    checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL single_src got %0h exp 0", out_src); end
    checks++; if (out_data !== 16'hA5C3) begin errors++; $display("FAIL single_data got %0h exp a5c3", out_data); end
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready got %0h exp 1", req_ready); end
    cyc();
    req_valid = 3'b000;
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin errors++; $display("FAIL single_idle got valid=%0h data=%0h exp 0 0", out_valid, out_data); end
    checks++; if (dut.cnt[0] !== 2'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", dut.cnt[0]); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0h exp 1", busy); end
    done = 3'b001;
    cyc();
    done = 3'b000;
    checks++; if (dut.cnt[0] !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL single_credit got cnt=%0d busy=%0h exp 0 0", dut.cnt[0], busy); end
  endtask

  task automatic test_back_to_back();
    int exp_src;
    int prev;
    set_data(0, 16'h1000);
    set_data(1, 16'h1001);
    req_valid = 3'b011;
    out_ready = 1'b1;
    cyc();
    exp_src = 1;
    prev = -1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (out_valid !== 1'b1 || out_src !== 2'(exp_src)) begin errors++; $display("FAIL b2b_grant[%0d] got valid=%0h src=%0d exp 1 %0d", k, out_valid, out_src, exp_src); end
      checks++; if (req_ready !== onehot(exp_src) || out_data !== 16'(16'h1000 + exp_src)) begin errors++; $display("FAIL b2b_ready_data[%0d] got ready=%0h data=%0h exp %0h %0h", k, req_ready, out_data, onehot(exp_src), 16'h1000 + exp_src); end
      done = (prev >= 0) ? 3'(onehot(prev)) : 3'b000;
      if (k == 7) req_valid = 3'(onehot(exp_src));
      prev = exp_src;
      exp_src = 1 - exp_src;
      cyc();
    end
    req_valid = 3'b000;
    done = 3'b011;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_idle got %0h exp 0", out_valid); end
    cyc();
    done = 3'b000;
    checks++; if (busy !== 1'b0 || dut.cnt[1] !== 2'd0) begin errors++; $display("FAIL b2b_drain got busy=%0h cnt1=%0d exp 0 0", busy, dut.cnt[1]); end
  endtask

  task automatic test_backpressure();
    set_data(1, 16'hBEEF);
    req_valid = 3'b010;
    out_ready = 1'b0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 16'hBEEF || req_ready !== 3'b000) begin
        errors++; $display("FAIL bp_hold[%0d] got valid=%0h src=%0d data=%0h ready=%0h exp 1 1 beef 0", k, out_valid, out_src, out_data, req_ready);
      end
      if (k < 4) cyc();
    end
    checks++; if (dut.cnt[1] !== 2'd0) begin errors++; $display("FAIL bp_no_push got %0d exp 0", dut.cnt[1]); end
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL bp_release_ready got %0h exp 2", req_ready); end
    cyc();
    req_valid = 3'b000;
    cyc();
    checks++; if (dut.cnt[1] !== 2'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_push got cnt=%0d valid=%0h exp 1 0", dut.cnt[1], out_valid); end
    done = 3'b010;
    cyc();
    done = 3'b000;
  endtask

  task automatic test_credit_limit();
    set_data(0, 16'h0C0C);
    set_data(1, 16'h1111);
    req_valid = 3'b001;
    out_ready = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin errors++; $display("FAIL cr_first got valid=%0h src=%0d exp 1 0", out_valid, out_src); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cr_gap1 got %0h exp 0", out_valid); end
    cyc();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin errors++; $display("FAIL cr_second got valid=%0h src=%0d exp 1 0", out_valid, out_src); end
    cyc();
    checks++; if (out_valid !== 1'b0 || dut.cnt[0] !== 2'd2) begin errors++; $display("FAIL cr_full got valid=%0h cnt=%0d exp 0 2", out_valid, dut.cnt[0]); end
    cyc();
    checks++; if (out_valid !== 1'b0 || req_ready !== 3'b000) begin errors++; $display("FAIL cr_skipped got valid=%0h ready=%0h exp 0 0", out_valid, req_ready); end
    req_valid = 3'b011;
    cyc();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd1) begin errors++; $display("FAIL cr_other got valid=%0h src=%0d exp 1 1", out_valid, out_src); end
    cyc();
    req_valid = 3'b001;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cr_stay_idle got %0h exp 0", out_valid); end
    done = 3'b001;
    cyc();
    done = 3'b000;
    checks++; if (out_valid !== 1'b0 || dut.cnt[0] !== 2'd1) begin errors++; $display("FAIL cr_returned got valid=%0h cnt=%0d exp 0 1", out_valid, dut.cnt[0]); end
    cyc();
    checks++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin errors++; $display("FAIL cr_regrant got valid=%0h src=%0d exp 1 0", out_valid, out_src); end
    done = 3'b001;
    cyc();
    req_valid = 3'b000;
    done = 3'b000;
    checks++; if (dut.cnt[0] !== 2'd1) begin errors++; $display("FAIL cr_push_and_done got %0d exp 1", dut.cnt[0]); end
    done = 3'b010;
    cyc();
    checks++; if (dut.cnt[1] !== 2'd0) begin errors++; $display("FAIL cr_done1 got %0d exp 0", dut.cnt[1]); end
    cyc();
    checks++; if (dut.cnt[1] !== 2'd0) begin errors++; $display("FAIL cr_saturate got %0d exp 0", dut.cnt[1]); end
    done = 3'b001;
    cyc();
    done = 3'b000;
    checks++; if (dut.cnt[0] !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL cr_drain got cnt=%0d busy=%0h exp 0 0", dut.cnt[0], busy); end
  endtask

  task automatic test_reset_mid_grant();
    set_data(0, 16'h5A5A);
    req_valid = 3'b001;
    out_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    out_ready = 1'b0;
    cyc();
    checks++; if (out_valid !== 1'b1 || dut.cnt[0] !== 2'd1 || dut.ptr !== 2'd1) begin errors++; $display("FAIL rmg_pre got valid=%0h cnt=%0d ptr=%0d exp 1 1 1", out_valid, dut.cnt[0], dut.ptr); end
    reset = 1'b1;
    cyc();
    checks++; if (out_valid !== 1'b0 || req_ready !== 3'b000) begin errors++; $display("FAIL rmg_outputs got valid=%0h ready=%0h exp 0 0", out_valid, req_ready); end
    checks++; if (dut.ptr !== 2'd0 || dut.cnt[0] !== 2'd0 || dut.cnt[1] !== 2'd0 || dut.cnt[2] !== 2'd0) begin
      errors++; $display("FAIL rmg_state got ptr=%0d cnt=%0d/%0d/%0d exp 0 0/0/0", dut.ptr, dut.cnt[0], dut.cnt[1], dut.cnt[2]);
    end
`ifdef APB2AXI_ARB_STATS_EN
    checks++; if (grant_cnt !== '0) begin errors++; $display("FAIL rmg_stats got %0h exp 0", grant_cnt); end
`endif
    reset = 1'b0;
    req_valid = 3'b000;
    cyc();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmg_after got valid=%0h busy=%0h exp 0 0", out_valid, busy); end
  endtask

  task automatic test_random();
    bit         exp_busy;
    bit [N-1:0] exp_ready;
    for (int c = 0; c < 600; c++) begin
      exp_busy = m_grant;
      for (int i = 0; i < N; i++) if (m_cnt[i] > 0) exp_busy = 1'b1;
      exp_ready = (m_grant && out_ready && !reset) ? onehot(m_gnt) : '0;
      checks++; if (out_valid !== (m_grant && !reset)) begin errors++; $display("FAIL rnd_valid[%0d] got %0h exp %0h", c, out_valid, m_grant && !reset); end
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %0h exp %0h", c, req_ready, exp_ready); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy[%0d] got %0h exp %0h", c, busy, exp_busy); end
      if (m_grant) begin
        checks++; if (out_src !== 2'(m_gnt) || out_data !== req_data[m_gnt*W +: W]) begin
          errors++; $display("FAIL rnd_grant[%0d] got src=%0d data=%0h exp %0d %0h", c, out_src, out_data, m_gnt, req_data[m_gnt*W +: W]);
        end
      end else begin
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rnd_idle_data[%0d] got %0h exp 0", c, out_data); end
      end
      for (int i = 0; i < N; i++) begin
        checks++; if (dut.cnt[i] !== 2'(m_cnt[i])) begin errors++; $display("FAIL rnd_cnt%0d[%0d] got %0d exp %0d", i, c, dut.cnt[i], m_cnt[i]); end
`ifdef APB2AXI_ARB_STATS_EN
        checks++; if (grant_cnt[i*32 +: 32] !== m_gc[i]) begin errors++; $display("FAIL rnd_stats%0d[%0d] got %0d exp %0d", i, c, grant_cnt[i*32 +: 32], m_gc[i]); end
`endif
      end
      // New stimulus; a requester holds its entry until accepted.
      reset     = ($urandom_range(0, 79) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        done[i] = ($urandom_range(0, 3) == 0);
        if (!req_valid[i] || m_acc[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_data(i, 16'($urandom_range(0, 65535)));
        end
      end
      cyc();
    end
    reset     = 1'b0;
    req_valid = '0;
    done      = '0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    done      = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_credit_limit();
    test_reset_mid_grant();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
